// File: rtl/bcdn_pkg.sv
// ----------------------------------------------------------------------------
// bcdn_pkg
// Shared constants and types for the BCD up/down counter.
//   DIGIT_W     : width of one BCD digit
//   DIGIT_MAX   : largest legal value of one BCD digit
//   bcd_digit_t : one BCD digit
//   is_bcd()    : true when a 4-bit value is a legal BCD digit
// ----------------------------------------------------------------------------
package bcdn_pkg;

    localparam int DIGIT_W   = 4;
    localparam int DIGIT_MAX = 9;

    typedef logic [DIGIT_W-1:0] bcd_digit_t;

    function automatic logic is_bcd(input bcd_digit_t d);
        return (d <= bcd_digit_t'(DIGIT_MAX));
    endfunction

endpackage

// File: rtl/bcd_digit_cell.sv
// ----------------------------------------------------------------------------
// bcd_digit_cell
// One registered BCD digit with load, increment and (optionally) decrement.
// Configuration macro: BCDN_DOWN_EN adds the dec input and borrow_out output.
// Ports:
//   clk        : clock, rising edge
//   reset      : synchronous active-low reset, clears the digit
//   inc        : step the digit up by one this cycle
//   dec        : step the digit down by one this cycle (BCDN_DOWN_EN only)
//   ld         : load ld_val this cycle (wins over inc/dec)
//   ld_val     : value to load; an illegal digit is stored as 0
//   q          : current digit value, always 0..9
//   carry_out  : inc is requested while the digit sits at 9
//   borrow_out : dec is requested while the digit sits at 0 (BCDN_DOWN_EN only)
//   bad_ld     : ld is requested with an illegal ld_val
// ----------------------------------------------------------------------------
module bcd_digit_cell
    import bcdn_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               inc,
`ifdef BCDN_DOWN_EN
    input  logic               dec,
`endif
    input  logic               ld,
    input  logic [DIGIT_W-1:0] ld_val,
    output logic [DIGIT_W-1:0] q,
    output logic               carry_out,
`ifdef BCDN_DOWN_EN
    output logic               borrow_out,
`endif
    output logic               bad_ld
);

    localparam bcd_digit_t MAX_D = bcd_digit_t'(DIGIT_MAX);

    // Carry/borrow are combinational so the whole chain settles in one cycle.
    assign carry_out = inc && (q == MAX_D);
`ifdef BCDN_DOWN_EN
    assign borrow_out = dec && (q == '0);
`endif
    assign bad_ld = ld && !is_bcd(ld_val);

    always_ff @(posedge clk) begin
        if (!reset) begin
            q <= '0;
        end else if (ld) begin
            q <= is_bcd(ld_val) ? ld_val : '0;
        end else if (inc) begin
            q <= (q == MAX_D) ? '0 : q + bcd_digit_t'(1);
`ifdef BCDN_DOWN_EN
        end else if (dec) begin
            q <= (q == '0) ? MAX_D : q - bcd_digit_t'(1);
`endif
        end
    end

endmodule

// File: rtl/bcdn_counter.sv
// ----------------------------------------------------------------------------
// bcdn_counter
// DIGITS-digit BCD counter with parallel load, wrap or saturate at the range
// limit, a one-cycle limit pulse and a sticky illegal-load flag.
// Configuration macro: BCDN_DOWN_EN adds the dn port and decrement support.
// Parameters:
//   DIGITS : number of BCD digits (1..8)
//   WRAP   : 1 = wrap at the range limit, 0 = saturate at the range limit
// Ports:
//   clk      : clock, rising edge
//   reset    : synchronous active-low reset
//   x        : count enable, one step per cycle
//   load     : parallel load strobe (wins over x)
//   load_val : BCD value to load, digit 0 in [3:0]
//   dn       : 1 = count down (BCDN_DOWN_EN only)
//   bcd_out  : registered count, digit 0 in [3:0]
//   wrap     : one-cycle pulse after a range-limit crossing or saturation hit
//   err      : sticky, set by a load containing a digit above 9
// ----------------------------------------------------------------------------
module bcdn_counter
    import bcdn_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter bit WRAP   = 1'b1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      x,
    input  logic                      load,
    input  logic [DIGIT_W*DIGITS-1:0] load_val,
`ifdef BCDN_DOWN_EN
    input  logic                      dn,
`endif
    output logic [DIGIT_W*DIGITS-1:0] bcd_out,
    output logic                      wrap,
    output logic                      err
);

    logic [DIGITS-1:0]         inc_v;
    logic [DIGITS-1:0]         carry_v;
    logic [DIGITS-1:0]         bad_v;
    logic                      limit_evt;
    logic                      sat_hold;
    logic                      ld_all;
    logic [DIGIT_W*DIGITS-1:0] ld_bus;

`ifdef BCDN_DOWN_EN
    logic [DIGITS-1:0] dec_v;
    logic [DIGITS-1:0] borrow_v;

    assign inc_v[0] = x && !load && !dn;
    assign dec_v[0] = x && !load && dn;
    // A carry or borrow out of the top digit is exactly the range-limit event.
    assign limit_evt = carry_v[DIGITS-1] || borrow_v[DIGITS-1];
`else
    assign inc_v[0] = x && !load;
    assign limit_evt = carry_v[DIGITS-1];
`endif

    // Saturation is done by reloading the current value into every cell,
    // which overrides the step the chain would otherwise apply.
    assign sat_hold = (WRAP == 1'b0) && limit_evt;
    assign ld_all   = load || sat_hold;
    assign ld_bus   = load ? load_val : bcd_out;

    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        if (i > 0) begin : g_chain
            assign inc_v[i] = carry_v[i-1];
`ifdef BCDN_DOWN_EN
            assign dec_v[i] = borrow_v[i-1];
`endif
        end

        bcd_digit_cell u_cell (
            .clk        (clk),
            .reset      (reset),
            .inc        (inc_v[i]),
`ifdef BCDN_DOWN_EN
            .dec        (dec_v[i]),
`endif
            .ld         (ld_all),
            .ld_val     (ld_bus[DIGIT_W*i +: DIGIT_W]),
            .q          (bcd_out[DIGIT_W*i +: DIGIT_W]),
            .carry_out  (carry_v[i]),
`ifdef BCDN_DOWN_EN
            .borrow_out (borrow_v[i]),
`endif
            .bad_ld     (bad_v[i])
        );
    end

    // limit_evt is already zero during a load because the chain input is
    // gated by load, so a load can never raise wrap.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wrap <= 1'b0;
            err  <= 1'b0;
        end else begin
            wrap <= limit_evt;
            err  <= err || (load && (|bad_v));
        end
    end

endmodule
